// File: rtl/jt49_div_meas.sv
// rtl/jt49_div_meas.sv - measures the period of a divided clock-enable train in base cen ticks
module jt49_div_meas #(
   parameter int W    = 4,
   parameter int TOUT = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cen,
   input  logic         pulse_in,
   output logic [W-1:0] period,
   output logic         valid,
   output logic         locked,
   output logic         ovf
);

   typedef enum logic {IDLE, MEAS} state_t;

   localparam logic [W+1:0] MAX_PER = {2'b00, {W{1'b1}}};
   localparam logic [W+1:0] TOUT_C  = TOUT[W+1:0];

   state_t       state;
   logic [W+1:0] cnt;
   logic [W+1:0] prev;
   logic [W+1:0] cnt_nx;
   logic         in_range;

   // cnt already holds the length of the interval that ends on this tick
   assign cnt_nx   = cnt + 1'b1;
   assign in_range = (cnt <= MAX_PER);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         prev   <= '0;
         period <= '0;
         valid  <= 1'b0;
         locked <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (cen) begin
            case (state)
               IDLE: begin
                  if (pulse_in) begin
                     cnt   <= {{(W+1){1'b0}}, 1'b1};
                     state <= MEAS;
                  end
               end
               MEAS: begin
                  if (pulse_in) begin
                     if (in_range) begin
                        period <= cnt[W-1:0];
                        ovf    <= 1'b0;
                     end else begin
                        period <= '1;
                        ovf    <= 1'b1;
                     end
                     valid  <= 1'b1;
                     locked <= (cnt == prev) && in_range;
                     prev   <= cnt;
                     cnt    <= {{(W+1){1'b0}}, 1'b1};
                  end else if (cnt_nx == TOUT_C) begin
                     // no pulse for too long: drop lock and re-arm on the next pulse
                     state  <= IDLE;
                     ovf    <= 1'b1;
                     locked <= 1'b0;
                     cnt    <= '0;
                  end else begin
                     cnt <= cnt_nx;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
